// File: rtl/dual_edge_gen.sv
// Rebuilds a level waveform from edge ticks, holding each new level for at least
// MIN_HOLD cycles and replaying ticks that arrive during a hold from a pending counter.
module dual_edge_gen #(
  parameter int MIN_HOLD = 4,
  parameter int PEND_W   = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  output logic              o_level,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_busy,
  output logic              o_overflow
);

  localparam int CNT_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(MIN_HOLD - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  // Bit 0 of the encoding is the output level, so o_level comes straight off a flop
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    HOLD_HI = 2'b01,
    IDLE_HI = 2'b11,
    HOLD_LO = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [CNT_W-1:0]  r_holdCnt;
  logic [CNT_W-1:0]  w_holdCntNext;
  logic [PEND_W-1:0] r_pending;
  logic [PEND_W-1:0] w_pendingNext;
  logic              r_overflow;
  logic              w_work;
  logic              w_inHold;
  logic              w_expired;
  logic              w_toggle;
  logic              w_drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE_LO;
      r_holdCnt  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_holdCnt  <= w_holdCntNext;
      r_pending  <= w_pendingNext;
      r_overflow <= w_drop;
    end
  end

  always_comb begin
    w_work        = i_tick | (r_pending != '0);
    w_inHold      = (r_state == HOLD_HI) || (r_state == HOLD_LO);
    w_expired     = (r_holdCnt == '0);
    w_toggle      = w_work & (~w_inHold | w_expired);
    w_stateNext   = r_state;
    w_holdCntNext = r_holdCnt;
    w_pendingNext = r_pending;
    w_drop        = 1'b0;

    case (r_state)
      IDLE_LO: if (w_work) w_stateNext = HOLD_HI;
      IDLE_HI: if (w_work) w_stateNext = HOLD_LO;
      HOLD_HI: if (w_expired) w_stateNext = w_work ? HOLD_LO : IDLE_HI;
      HOLD_LO: if (w_expired) w_stateNext = w_work ? HOLD_HI : IDLE_LO;
      default: w_stateNext = IDLE_LO;
    endcase

    if (w_toggle) begin
      w_holdCntNext = HOLD_LOAD;
    end else if (w_inHold && !w_expired) begin
      w_holdCntNext = r_holdCnt - 1'b1;
    end

    // A toggle with a same-cycle tick leaves the count unchanged: one tick in, one out
    if (w_toggle) begin
      if (r_pending != '0 && !i_tick) w_pendingNext = r_pending - 1'b1;
    end else if (i_tick) begin
      if (r_pending != PEND_MAX) w_pendingNext = r_pending + 1'b1;
      else                       w_drop        = 1'b1;
    end
  end

  assign o_level    = r_state[0];
  assign o_pending  = r_pending;
  assign o_busy     = w_inHold || (r_pending != '0);
  assign o_overflow = r_overflow;

endmodule
